axis_fifo_sync: RTL and testbench

- Single-clock FIFO with AXI-Stream-style valid/ready on both sides, first-word-fall-through output, and an occupancy count.
- Programmable almost-full/almost-empty flags, synchronous flush, and sticky error flags for protocol violations.
- Sits between AXI stream producers and consumers inside the clock domain.
- Replaces the rden/wren FIFO style, whose caller must check full/bare itself.

---
 rtl/axis_fifo_sync.sv | 112 +++++++++++
 tb/tb_axis_fifo_sync.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_sync.sv
// Single-clock valid/ready FIFO with a one-cycle fall-through output register,
// occupancy count, programmable level flags, synchronous flush and sticky protocol error flags.
module axis_fifo_sync #(
  parameter int    PWID      = 4,
  parameter int    DWID      = 32,
  parameter int    AFULL_TH  = 12,
  parameter int    AEMPTY_TH = 2,
  parameter string RAM_STYLE = "block"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DWID-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DWID-1:0] m_data,
  output logic [PWID:0]   count,
  output logic            almost_full,
  output logic            almost_empty,
  output logic            err_drop,
  output logic            err_unstable
);

  localparam int            DEPTH   = 2**PWID;
  localparam logic [PWID:0] PTR_ONE = (PWID+1)'(1);
  localparam logic [PWID:0] AF_LVL  = (PWID+1)'(AFULL_TH);
  localparam logic [PWID:0] AE_LVL  = (PWID+1)'(AEMPTY_TH);

  if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH ||
      (RAM_STYLE != "block" && RAM_STYLE != "distributed" && RAM_STYLE != "registers"))
  begin : g_param_check
    $error("axis_fifo_sync: illegal parameter value");
  end

  (* ram_style = RAM_STYLE *) logic [DWID-1:0] mem [DEPTH];

  logic [PWID:0]   wptr, rptr, rptr_inc;
  logic [PWID:0]   wptr_next, rptr_next, count_next;
  logic [PWID-1:0] load_addr;
  logic            wr, rd, load, valid_next, full_next;
  logic            drop_pend, stall_pend;

  assign wr       = s_valid & s_ready & ~flush;
  assign rd       = m_valid & m_ready & ~flush;
  assign rptr_inc = rptr + PTR_ONE;

  // The head entry stays in storage (and in count) until it is read; m_data is a copy of it.
  always_comb begin
    wptr_next  = wptr;
    rptr_next  = rptr;
    valid_next = m_valid;
    load       = 1'b0;
    load_addr  = rptr[PWID-1:0];
    if (flush) begin
      wptr_next  = '0;
      rptr_next  = '0;
      valid_next = 1'b0;
    end else begin
      if (wr) wptr_next = wptr + PTR_ONE;
      if (rd) begin
        rptr_next  = rptr_inc;
        valid_next = (wptr != rptr_inc);
        load       = (wptr != rptr_inc);
        load_addr  = rptr_inc[PWID-1:0];
      end else if (!m_valid && (wptr != rptr)) begin
        valid_next = 1'b1;
        load       = 1'b1;
      end
    end
    count_next = wptr_next - rptr_next;
    full_next  = (wptr_next[PWID] != rptr_next[PWID]) &&
                 (wptr_next[PWID-1:0] == rptr_next[PWID-1:0]);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[PWID-1:0]] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      s_ready      <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      drop_pend    <= 1'b0;
      stall_pend   <= 1'b0;
      err_drop     <= 1'b0;
      err_unstable <= 1'b0;
    end else begin
      wptr         <= wptr_next;
      rptr         <= rptr_next;
      count        <= count_next;
      m_valid      <= valid_next;
      if (load) m_data <= mem[load_addr];
      s_ready      <= ~full_next;
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
      // A flush legitimately withdraws m_valid, so it must not arm the stability check.
      drop_pend    <= s_valid & ~s_ready;
      stall_pend   <= m_valid & ~m_ready & ~flush;
      if (drop_pend && !s_valid)  err_drop     <= 1'b1;
      if (stall_pend && !m_valid) err_unstable <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_fifo_sync.sv
// Bench for axis_fifo_sync (DEPTH=4): directed scenarios plus random traffic, checked
// against a queue model where the head is visible once it was written at an earlier edge.
module tb_axis_fifo_sync;

  localparam int DEPTH = 4;
  localparam logic [8:0] RESET_VEC = 9'b000000100;

  logic       clk = 1'b0;
  logic       rst, flush, s_valid, m_ready;
  logic [7:0] s_data, m_data;
  logic       s_ready, m_valid, almost_full, almost_empty, err_drop, err_unstable;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  typedef struct { logic [7:0] d; int t; } beat_t;
  beat_t q[$];
  bit         exp_sready, exp_mvalid, exp_drop, pend, rd_hit;
  logic [7:0] rd_val;

  axis_fifo_sync #(.PWID(2), .DWID(8), .AFULL_TH(3), .AEMPTY_TH(1), .RAM_STYLE("distributed")) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .err_drop(err_drop), .err_unstable(err_unstable)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs_vec();
    return {s_ready, m_valid, count, almost_full, almost_empty, err_drop, err_unstable};
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [2:0] c;
    c = 3'(q.size());
    return {exp_sready, exp_mvalid, c, (q.size() >= 3), (q.size() <= 1), exp_drop, 1'b0};
  endfunction

  task automatic model_reset();
    q.delete();
    exp_sready = 0;
    exp_mvalid = 0;
    exp_drop   = 0;
    pend       = 0;
  endtask

  // One clock edge: derive transfers from the model, advance, sample #1 after the edge.
  task automatic step();
    bit wr, rd;
    wr = s_valid && exp_sready && !flush;
    rd = exp_mvalid && m_ready && !flush;
    rd_hit = rd;
    rd_val = m_data;
    if (pend && !s_valid) exp_drop = 1;
    pend = s_valid && !exp_sready;
    @(posedge clk);
    edge_n++;
    if (flush) q.delete();
    else begin
      if (rd) void'(q.pop_front());
      if (wr) q.push_back('{d: s_data, t: edge_n});
    end
    exp_sready = (q.size() != DEPTH);
    exp_mvalid = (q.size() > 0) && (q[0].t < edge_n);
    #1;
  endtask

  task automatic test_reset();
    rst = 0; flush = 0; s_valid = 0; m_ready = 0; s_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (obs_vec() !== RESET_VEC) begin bad++; $display("FAIL reset_flags: got %b want %b", obs_vec(), RESET_VEC); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", m_data); end
    @(posedge clk); #1 rst = 1;
    step();
    total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL release: got %b want %b", obs_vec(), exp_vec()); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_ready = 0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = vals[i];
      step();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL fill[%0d]: got %b want %b", i, obs_vec(), exp_vec()); end
      total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
    end
    s_data = 8'h55;
    step();
    total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL fill_over: got %b want %b", obs_vec(), exp_vec()); end
    total++; if (count !== 3'd4 || s_ready !== 1'b0) begin bad++; $display("FAIL fill_over_lvl: got count=%0d ready=%b want 4/0", count, s_ready); end
  endtask

  task automatic test_full_drain();
    logic [7:0] want [5];
    int n;
    want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    n = 0;
    m_ready = 1;
    for (int c = 0; c < 15 && n < 5; c++) begin
      bit wrote;
      wrote = s_valid && exp_sready;
      step();
      if (wrote) s_valid = 0;
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL drain[%0d]: got %b want %b", c, obs_vec(), exp_vec()); end
      if (rd_hit) begin
        total++; if (rd_val !== want[n]) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", n, rd_val, want[n]); end
        n++;
      end
    end
    total++; if (n != 5) begin bad++; $display("FAIL drain_timeout: got %0d reads want 5", n); end
    s_valid = 0;
  endtask

  task automatic test_single();
    m_ready = 1; s_valid = 0;
    repeat (2) step();
    s_valid = 1; s_data = 8'hA5;
    step();
    s_valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL single[%0d]: got %b want %b", i, obs_vec(), exp_vec()); end
      if (i == 1) begin
        total++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin bad++; $display("FAIL single_out: got v=%b d=%h want 1/a5", m_valid, m_data); end
      end
      if (i < 2) step();
    end
    total++; if (!rd_hit || rd_val !== 8'hA5 || count !== 3'd0 || almost_empty !== 1'b1) begin
      bad++; $display("FAIL single_read: got hit=%b d=%h count=%0d ae=%b want 1/a5/0/1", rd_hit, rd_val, count, almost_empty);
    end
  endtask

  task automatic test_stream();
    int n_snt, n_rcv;
    n_snt = 0; n_rcv = 0;
    m_ready = 1;
    for (int c = 0; c < 40 && n_rcv < 20; c++) begin
      bit wrote;
      s_valid = (n_snt < 20);
      s_data  = 8'(n_snt);
      wrote = s_valid && exp_sready;
      step();
      if (wrote) n_snt++;
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL stream[%0d]: got %b want %b", c, obs_vec(), exp_vec()); end
      if (rd_hit) begin
        total++; if (rd_val !== 8'(n_rcv)) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", n_rcv, rd_val, 8'(n_rcv)); end
        n_rcv++;
      end else if (n_rcv > 0) begin
        total++; bad++; $display("FAIL stream_gap: got no beat at cycle %0d want beat %0d", c, n_rcv);
      end
    end
    s_valid = 0;
    total++; if (n_rcv != 20) begin bad++; $display("FAIL stream_timeout: got %0d beats want 20", n_rcv); end
  endtask

  task automatic test_flush();
    int n;
    m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = 8'(i + 1);
      step();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL flush_fill[%0d]: got %b want %b", i, obs_vec(), exp_vec()); end
    end
    s_data = 8'h77; flush = 1;
    step();
    flush = 0;
    total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL flush_state: got %b want %b", obs_vec(), exp_vec()); end
    total++; if (count !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL flush_lvl: got count=%0d v=%b ready=%b want 0/0/1", count, m_valid, s_ready);
    end
    s_data = 8'h88;
    step();
    s_valid = 0; m_ready = 1;
    n = 0;
    while (!rd_hit && n < 6) begin
      step();
      n++;
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL flush_after[%0d]: got %b want %b", n, obs_vec(), exp_vec()); end
    end
    total++; if (!rd_hit || rd_val !== 8'h88) begin bad++; $display("FAIL flush_first: got hit=%b d=%h want 1/88", rd_hit, rd_val); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 31) == 0);
      step();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL random[%0d]: got %b want %b", c, obs_vec(), exp_vec()); end
      if (exp_mvalid) begin
        total++; if (m_data !== q[0].d) begin bad++; $display("FAIL random_data[%0d]: got %h want %h", c, m_data, q[0].d); end
      end
    end
    flush = 0; s_valid = 0; m_ready = 0;
  endtask

  task automatic test_async_reset();
    m_ready = 0; s_valid = 1;
    for (int i = 0; i < 2; i++) begin
      s_data = 8'($urandom);
      step();
    end
    #2 rst = 0;
    model_reset();
    #1;
    total++; if (obs_vec() !== RESET_VEC) begin bad++; $display("FAIL async_rst: got %b want %b", obs_vec(), RESET_VEC); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL async_rst_data: got %h want 00", m_data); end
    s_valid = 0;
    @(posedge clk); #1;
    total++; if (obs_vec() !== RESET_VEC) begin bad++; $display("FAIL async_hold: got %b want %b", obs_vec(), RESET_VEC); end
    rst = 1;
    step();
    total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL async_release: got %b want %b", obs_vec(), exp_vec()); end
  endtask

  task automatic test_err_drop();
    m_ready = 0; s_valid = 1;
    for (int c = 0; c < 8 && exp_sready; c++) begin
      s_data = 8'($urandom);
      step();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL drop_fill[%0d]: got %b want %b", c, obs_vec(), exp_vec()); end
    end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL drop_full: got ready=%b want 0", s_ready); end
    step();
    total++; if (err_drop !== 1'b0) begin bad++; $display("FAIL drop_early: got %b want 0", err_drop); end
    s_valid = 0;
    step();
    total++; if (err_drop !== 1'b1) begin bad++; $display("FAIL drop_set: got %b want 1", err_drop); end
    for (int c = 0; c < 8; c++) begin
      m_ready = 1'($urandom);
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      step();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL drop_sticky[%0d]: got %b want %b", c, obs_vec(), exp_vec()); end
    end
    #1 rst = 0;
    model_reset();
    #1;
    total++; if (err_drop !== 1'b0) begin bad++; $display("FAIL drop_clear: got %b want 0", err_drop); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_drain();
    test_single();
    test_stream();
    test_flush();
    test_random();
    test_async_reset();
    test_err_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
